conv3x3_stream_engine: RTL and testbench
========================================

Name: conv3x3_stream_engine

Overview:
- Parametrised successor to the fixed 28-column convolution top.
- Accepts a row-major pixel stream over valid/ready and buffers two image rows internally.
- Computes a 3x3 signed-kernel convolution at stride 1 or 2, then applies a shift, ReLU/saturation post-process.
- Emits results with destination addresses over valid/ready, for direct connection to the feature-map writer.

Parameters:
- BIT_DEPTH, 8, pixel/kernel/output width.
- IMG_W, 28, image width in pixels (>=3).
- IMG_H, 28, image height in rows (>=3).
- ACC_W, 20, signed accumulator width; must hold 9*(2^BIT_DEPTH-1)*2^(BIT_DEPTH-1) plus sign.
- ADDR_W, 10, output address width; must cover OUT_W*OUT_H.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- kernel_wr_en  in  1  kernel register write strobe; honoured only when busy=0.
- kernel_wr_addr  in  4  kernel index row*3+col, row 0 = oldest row; 9..15 ignored.
- kernel_wr_data  in  BIT_DEPTH  signed kernel coefficient.
- start  in  1  begin a frame; ignored while busy=1.
- stride  in  2  2'd2 selects stride 2; any other value selects stride 1. Latched on start.
- relu_en  in  1  post-process mode. Latched on start.
- shift_amt  in  5  arithmetic right shift applied to the sum. Latched on start.
- pix_valid  in  1  pixel handshake valid.
- pix_data  in  BIT_DEPTH  unsigned pixel.
- pix_ready  out  1  pixel handshake ready.
- out_valid  out  1  result valid.
- out_data  out  BIT_DEPTH  post-processed result.
- out_addr  out  ADDR_W  result index orow*OUT_W+ocol.
- out_ready  in  1  result consumer ready.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE; all outputs go to 0.
  - Kernel registers, line buffers, window and counters are cleared.
  - Reset mid-frame abandons the frame; any pending output is dropped.
- Derived sizes: S = 1 or 2; OUT_W = (IMG_W-3)/S+1; OUT_H = (IMG_H-3)/S+1 (integer division).
  - 28x28 gives 26x26 at S=1 and 13x13 at S=2.
- FSM IDLE -> RUN -> FLUSH -> IDLE.
  - IDLE: kernel writes are accepted. start=1 latches the mode inputs, clears the row/col/out counters, and moves to RUN.
  - RUN: pix_ready = !out_valid || out_ready. A handshake happens when pix_valid && pix_ready.
  - RUN exit: on acceptance of pixel number IMG_W*IMG_H, go to FLUSH.
  - FLUSH: pix_ready=0. Once out_valid=0, or when a handshake completes this cycle, pulse done for one cycle and go to IDLE.
- Per accepted pixel at (r,c):
  - Shift the two line buffers at column c; update the 3x3 window with the column {row r-2, row r-1, incoming pixel}.
  - Increment c, wrapping at IMG_W-1 and incrementing r.
- Output generation: when r>=2, c>=2, (r-2)%S==0 and (c-2)%S==0, the window including the incoming pixel is complete.
  - The result is registered on the same edge: out_valid=1 one cycle after that pixel's handshake (latency 1).
  - out_addr counts 0,1,2,... in raster order.
  - Windows never span a row boundary; pixels in columns/rows skipped by the stride are consumed without output.
- Hold rule: while out_valid && !out_ready, out_data and out_addr hold and no pixel is accepted.
  - A handshake and a new result in the same cycle replace the register without a bubble.
- Arithmetic:
  - sum = sigma k[i]*p[i] with pixels zero-extended and kernel sign-extended, accumulated at ACC_W.
  - sh = sum >>> shift_amt.
  - relu_en=1: clamp sh to [0, 2^BIT_DEPTH-1], unsigned.
  - relu_en=0: clamp sh to [-2^(BIT_DEPTH-1), 2^(BIT_DEPTH-1)-1], two's complement.
- Boundary and edge cases:
  - Kernel writes while busy=1 are ignored, so the kernel is stable for the whole frame.
  - start in the same cycle as kernel_wr_en: the write takes effect (IDLE) and the frame uses the new value.
  - pix_valid is ignored outside RUN.
  - done never coincides with busy=0 in the same cycle; busy drops the cycle after done.

Test Plan:
- Identity kernel (k[4]=1, others 0), S=1, relu=1, shift=0, pixel (r*28+c)%256: first output addr 0 = 29, addr 1 = 30; 676 outputs total, done pulses exactly once.
- All-ones kernel, stride=2, constant pixel 10: 169 outputs, addresses 0..168, each = 90; the final 28-pixel row is consumed with no output.
- All-ones kernel, pixel 255: relu=1/shift=0 -> 255 (2295 saturates); relu=0 -> 127; relu=1/shift=4 -> 143.
- k[4]=-1 (0xFF), pixel 50: relu=1 -> 0x00; relu=0 -> 0xCE (-50).
- Hold out_ready low for 5 cycles while out_valid=1: pix_ready=0 throughout, out_data/out_addr stable, no skipped or duplicated addresses after release.
- Drive rst=0 mid-frame: all outputs 0 next cycle and kernel cleared. A kernel write during busy is ignored; start with pix_valid held low stays in RUN with no outputs.

Source files
------------

// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 signed-kernel convolution over a row-major pixel stream.
// Two line buffers plus a sliding window; stride 1/2, shift and ReLU/saturation post-process.
module conv3x3_stream_engine #(
    parameter int BIT_DEPTH = 8,
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int ACC_W     = 20,
    parameter int ADDR_W    = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 kernel_wr_en,
    input  logic [3:0]           kernel_wr_addr,
    input  logic [BIT_DEPTH-1:0] kernel_wr_data,
    input  logic                 start,
    input  logic [1:0]           stride,
    input  logic                 relu_en,
    input  logic [4:0]           shift_amt,
    input  logic                 pix_valid,
    input  logic [BIT_DEPTH-1:0] pix_data,
    output logic                 pix_ready,
    output logic                 out_valid,
    output logic [BIT_DEPTH-1:0] out_data,
    output logic [ADDR_W-1:0]    out_addr,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic signed [ACC_W-1:0] U_MAX = ACC_W'((2 ** BIT_DEPTH) - 1);
    localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((2 ** (BIT_DEPTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] S_MIN = ACC_W'(-(2 ** (BIT_DEPTH - 1)));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [CW-1:0]        col_reg;
    logic [RW-1:0]        row_reg;
    logic                 stride2_reg;
    logic                 relu_reg;
    logic [4:0]           shift_reg;
    logic [ADDR_W-1:0]    out_cnt_reg;
    logic                 out_valid_reg;
    logic [BIT_DEPTH-1:0] out_data_reg;
    logic [ADDR_W-1:0]    out_addr_reg;

    logic signed [BIT_DEPTH-1:0] kernel_reg [0:8];
    logic [BIT_DEPTH-1:0]        lb0_reg [0:IMG_W-1];
    logic [BIT_DEPTH-1:0]        lb1_reg [0:IMG_W-1];
    // Window columns c-2 and c-1 for each row; column c comes straight from the buffers/input.
    logic [BIT_DEPTH-1:0]        win_reg [0:5];

    logic [BIT_DEPTH-1:0]        col_tap [0:2];
    logic signed [ACC_W-1:0]     prod [0:8];
    logic signed [ACC_W-1:0]     sum;
    logic signed [ACC_W-1:0]     sh;
    logic [BIT_DEPTH-1:0]        res;

    logic pix_fire;
    logic col_last;
    logic last_pix;
    logic emit;
    logic kernel_we;

    assign col_last = (col_reg == CW'(IMG_W - 1));
    assign last_pix = col_last && (row_reg == RW'(IMG_H - 1));
    assign pix_fire = (state_reg == RUN) && pix_valid && pix_ready;
    assign kernel_we = (state_reg == IDLE) && kernel_wr_en && (kernel_wr_addr < 4'd9);

    // Stride 2 keeps even row/col offsets from 2, i.e. even indices.
    assign emit = (row_reg >= RW'(2)) && (col_reg >= CW'(2)) &&
                  (!stride2_reg || (!row_reg[0] && !col_reg[0]));

    assign col_tap[0] = lb0_reg[col_reg];
    assign col_tap[1] = lb1_reg[col_reg];
    assign col_tap[2] = pix_data;

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_tap
            localparam int R = gi / 3;
            localparam int C = gi % 3;
            logic [BIT_DEPTH-1:0]    pix_tap;
            logic signed [ACC_W-1:0] pix_ext;
            logic signed [ACC_W-1:0] k_ext;
            if (C == 2) begin : g_new
                assign pix_tap = col_tap[R];
            end else begin : g_old
                assign pix_tap = win_reg[R * 2 + C];
            end
            assign pix_ext = {{(ACC_W - BIT_DEPTH){1'b0}}, pix_tap};
            assign k_ext   = {{(ACC_W - BIT_DEPTH){kernel_reg[gi][BIT_DEPTH-1]}}, kernel_reg[gi]};
            assign prod[gi] = pix_ext * k_ext;
        end
    endgenerate

    always_comb begin
        sum = '0;
        for (int i = 0; i < 9; i++) begin
            sum = sum + prod[i];
        end
        sh  = sum >>> shift_reg;
        res = sh[BIT_DEPTH-1:0];
        if (relu_reg) begin
            if (sh[ACC_W-1]) begin
                res = '0;
            end else if (sh > U_MAX) begin
                res = '1;
            end
        end else begin
            if (sh < S_MIN) begin
                res = {1'b1, {(BIT_DEPTH - 1){1'b0}}};
            end else if (sh > S_MAX) begin
                res = {1'b0, {(BIT_DEPTH - 1){1'b1}}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pix_ready  = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                pix_ready = !out_valid_reg || out_ready;
                if (pix_valid && pix_ready && last_pix) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (!out_valid_reg || out_ready) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state_reg != IDLE);
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_addr  = out_addr_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) begin
                kernel_reg[i] <= '0;
            end
        end else if (kernel_we) begin
            kernel_reg[kernel_wr_addr] <= kernel_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < IMG_W; i++) begin
                lb0_reg[i] <= '0;
                lb1_reg[i] <= '0;
            end
            for (int i = 0; i < 6; i++) begin
                win_reg[i] <= '0;
            end
        end else if (pix_fire) begin
            lb0_reg[col_reg] <= lb1_reg[col_reg];
            lb1_reg[col_reg] <= pix_data;
            for (int i = 0; i < 3; i++) begin
                win_reg[2 * i]     <= win_reg[2 * i + 1];
                win_reg[2 * i + 1] <= col_tap[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_reg       <= '0;
            row_reg       <= '0;
            stride2_reg   <= 1'b0;
            relu_reg      <= 1'b0;
            shift_reg     <= '0;
            out_cnt_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_addr_reg  <= '0;
        end else begin
            if (state_reg == IDLE && start) begin
                stride2_reg <= (stride == 2'd2);
                relu_reg    <= relu_en;
                shift_reg   <= shift_amt;
                col_reg     <= '0;
                row_reg     <= '0;
                out_cnt_reg <= '0;
            end else if (pix_fire) begin
                if (col_last) begin
                    col_reg <= '0;
                    row_reg <= row_reg + RW'(1);
                end else begin
                    col_reg <= col_reg + CW'(1);
                end
                if (emit) begin
                    out_cnt_reg <= out_cnt_reg + ADDR_W'(1);
                end
            end
            // A new result overwrites a consumed one in the same cycle, so no bubble.
            if (pix_fire && emit) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= res;
                out_addr_reg  <= out_cnt_reg;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// Self-checking bench for conv3x3_stream_engine: randomized frames against a
// direct convolution model, plus directed saturation, backpressure and reset scenarios.
module tb_conv3x3_stream_engine;

    localparam int BD  = 8;
    localparam int IW  = 28;
    localparam int IH  = 28;
    localparam int AW  = 20;
    localparam int ADW = 10;

    logic           clk = 1'b0;
    logic           rst;
    logic           kernel_wr_en;
    logic [3:0]     kernel_wr_addr;
    logic [BD-1:0]  kernel_wr_data;
    logic           start;
    logic [1:0]     stride;
    logic           relu_en;
    logic [4:0]     shift_amt;
    logic           pix_valid;
    logic [BD-1:0]  pix_data;
    logic           pix_ready;
    logic           out_valid;
    logic [BD-1:0]  out_data;
    logic [ADW-1:0] out_addr;
    logic           out_ready;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    conv3x3_stream_engine #(
        .BIT_DEPTH(BD), .IMG_W(IW), .IMG_H(IH), .ACC_W(AW), .ADDR_W(ADW)
    ) dut (
        .clk(clk), .rst(rst),
        .kernel_wr_en(kernel_wr_en), .kernel_wr_addr(kernel_wr_addr), .kernel_wr_data(kernel_wr_data),
        .start(start), .stride(stride), .relu_en(relu_en), .shift_amt(shift_amt),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    int checks = 0;
    int failures = 0;

    int img [0:IH-1][0:IW-1];
    int kern [0:8];
    int exp_q[$];
    int got_data[$];
    int got_addr[$];
    int done_cnt, prot_err, lat_err, idle_err;
    logic busy_after_done;
    bit timed_out;

    task automatic load_kernel();
        for (int i = 0; i < 9; i++) begin
            kernel_wr_en   = 1'b1;
            kernel_wr_addr = 4'(i);
            kernel_wr_data = BD'(kern[i]);
            @(posedge clk); #1;
        end
        kernel_wr_en = 1'b0;
    endtask

    // Direct 3x3 convolution of the whole image, in output raster order.
    task automatic build_expected(input int sv, input int rv, input int shv);
        int s, ow, oh, acc, v;
        s  = (sv == 2) ? 2 : 1;
        ow = (IW - 3) / s + 1;
        oh = (IH - 3) / s + 1;
        exp_q.delete();
        for (int orow = 0; orow < oh; orow++) begin
            for (int ocol = 0; ocol < ow; ocol++) begin
                acc = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        acc += kern[i * 3 + j] * img[orow * s + i][ocol * s + j];
                v = acc >>> shv;
                if (rv != 0) v = (v < 0) ? 0 : ((v > 255) ? 255 : v);
                else         v = (v < -128) ? -128 : ((v > 127) ? 127 : v);
                exp_q.push_back(v & 255);
            end
        end
    endtask

    task automatic random_image();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                img[r][c] = int'($urandom_range(0, 255));
    endtask

    task automatic run_frame(input int sv, input int rv, input int shv, input int pv_pct,
                             input int rdy_pct, input bit hold5, input int idle_cyc,
                             input int kw_idx);
        int idx, cyc, s, exp_addr, hold_left, pend_addr, r, c;
        bit held, prev_stall, pend_emit, fin;
        logic [BD-1:0]  pd;
        logic [ADW-1:0] pa;
        idx = 0; cyc = 0; exp_addr = 0; hold_left = 0; pend_addr = 0;
        held = 0; prev_stall = 0; pend_emit = 0; fin = 0; pd = '0; pa = '0;
        got_data.delete(); got_addr.delete();
        done_cnt = 0; prot_err = 0; lat_err = 0; idle_err = 0; timed_out = 0;
        busy_after_done = 1'bx;
        s = (sv == 2) ? 2 : 1;
        start = 1'b1; stride = 2'(sv); relu_en = rv[0]; shift_amt = 5'(shv);
        pix_valid = 1'b1; pix_data = BD'($urandom);
        if (kw_idx >= 0) begin
            kernel_wr_en = 1'b1; kernel_wr_addr = 4'(kw_idx); kernel_wr_data = BD'(kern[kw_idx]);
        end
        @(posedge clk); #1;
        start = 1'b0; kernel_wr_en = 1'b0; pix_valid = 1'b0;
        stride = 2'($urandom); relu_en = 1'($urandom); shift_amt = 5'($urandom);
        for (int i = 0; i < idle_cyc; i++) begin
            kernel_wr_en = 1'b1; kernel_wr_addr = 4'($urandom_range(0, 8)); kernel_wr_data = BD'($urandom);
            @(negedge clk);
            if (busy !== 1'b1 || out_valid !== 1'b0 || pix_ready !== 1'b1) idle_err++;
            @(posedge clk); #1;
        end
        kernel_wr_en = 1'b0;
        while (!fin) begin
            pix_valid = (idx < IW * IH) && ($urandom_range(0, 99) < pv_pct);
            pix_data  = (idx < IW * IH) ? BD'(img[idx / IW][idx % IW]) : BD'($urandom);
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            if (hold_left > 0) begin
                out_ready = 1'b0;
                hold_left--;
            end
            @(negedge clk);
            if (pend_emit && (out_valid !== 1'b1 || out_addr !== ADW'(pend_addr))) lat_err++;
            pend_emit = 0;
            if (prev_stall && (out_valid !== 1'b1 || out_data !== pd || out_addr !== pa)) prot_err++;
            if (out_valid === 1'b1 && !out_ready && pix_ready !== 1'b0) prot_err++;
            if (done === 1'b1) begin
                done_cnt++;
                if (busy !== 1'b1) prot_err++;
                fin = 1;
            end
            if (out_valid === 1'b1 && out_ready) begin
                got_data.push_back(int'(out_data));
                got_addr.push_back(int'(out_addr));
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            pd = out_data; pa = out_addr;
            if (pix_valid && pix_ready === 1'b1) begin
                r = idx / IW; c = idx % IW;
                if (r >= 2 && c >= 2 && (r - 2) % s == 0 && (c - 2) % s == 0) begin
                    pend_emit = 1; pend_addr = exp_addr; exp_addr++;
                end
                idx++;
            end
            if (hold5 && !held && out_valid === 1'b1) begin
                held = 1; hold_left = 5;
            end
            cyc++;
            if (cyc > 20000) begin
                timed_out = 1; fin = 1;
            end
            @(posedge clk); #1;
        end
        pix_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) busy_after_done = busy;
            if (done === 1'b1) done_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; pix_valid = 1'b1; pix_data = 8'd77; out_ready = 1'b1;
        kernel_wr_en = 1'b0; kernel_wr_addr = '0; kernel_wr_data = '0;
        stride = '0; relu_en = 1'b0; shift_amt = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
        checks++; if (out_addr !== '0) begin failures++; $display("FAIL reset_out_addr got=%0d want=0", out_addr); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL reset_pix_ready got=%b want=0", pix_ready); end
        @(posedge clk); #1;
        start = 1'b0; pix_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_identity();
        for (int i = 0; i < 9; i++) kern[i] = (i == 4) ? 1 : 0;
        for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = (r * 28 + c) % 256;
        load_kernel();
        build_expected(1, 1, 0);
        run_frame(1, 1, 0, 85, 70, 0, 0, -1);
        checks++; if (timed_out) begin failures++; $display("FAIL identity_timeout got=timeout want=done"); end
        checks++; if (got_data.size() != 676) begin failures++; $display("FAIL identity_count got=%0d want=676", got_data.size()); end
        checks++; if (got_data.size() < 2 || got_data[0] != 29 || got_data[1] != 30) begin
            failures++; $display("FAIL identity_first_two got=%0d,%0d want=29,30",
                                 (got_data.size() > 0) ? got_data[0] : -1, (got_data.size() > 1) ? got_data[1] : -1);
        end
        for (int i = 0; i < got_data.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_data[i] != exp_q[i] || got_addr[i] != i) begin
                failures++; $display("FAIL identity_out[%0d] got data=%0d addr=%0d want data=%0d addr=%0d",
                                     i, got_data[i], got_addr[i], exp_q[i], i);
            end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL identity_done_count got=%0d want=1", done_cnt); end
        checks++; if (busy_after_done !== 1'b0) begin failures++; $display("FAIL identity_busy_after_done got=%b want=0", busy_after_done); end
        checks++; if (prot_err != 0 || lat_err != 0) begin failures++; $display("FAIL identity_protocol got=%0d/%0d want=0/0", prot_err, lat_err); end
    endtask

    task automatic test_stride2();
        for (int i = 0; i < 9; i++) kern[i] = 1;
        for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = 10;
        load_kernel();
        run_frame(2, 1, 0, 90, 80, 0, 0, -1);
        checks++; if (timed_out) begin failures++; $display("FAIL stride2_timeout got=timeout want=done"); end
        checks++; if (got_data.size() != 169) begin failures++; $display("FAIL stride2_count got=%0d want=169", got_data.size()); end
        for (int i = 0; i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] != 90 || got_addr[i] != i) begin
                failures++; $display("FAIL stride2_out[%0d] got data=%0d addr=%0d want data=90 addr=%0d", i, got_data[i], got_addr[i], i);
            end
        end
        checks++; if (done_cnt != 1 || prot_err != 0 || lat_err != 0) begin
            failures++; $display("FAIL stride2_protocol got done=%0d err=%0d/%0d want done=1 err=0/0", done_cnt, prot_err, lat_err);
        end
    endtask

    task automatic test_saturation();
        int rv_t [0:2];
        int sh_t [0:2];
        int want [0:2];
        rv_t = '{1, 0, 1}; sh_t = '{0, 0, 4}; want = '{255, 127, 143};
        for (int i = 0; i < 9; i++) kern[i] = 1;
        for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = 255;
        load_kernel();
        for (int m = 0; m < 3; m++) begin
            run_frame(1, rv_t[m], sh_t[m], 95, 90, 0, 0, -1);
            checks++; if (got_data.size() != 676) begin failures++; $display("FAIL sat%0d_count got=%0d want=676", m, got_data.size()); end
            for (int i = 0; i < got_data.size(); i++) begin
                checks++;
                if (got_data[i] != want[m] || got_addr[i] != i) begin
                    failures++; $display("FAIL sat%0d_out[%0d] got data=%0d addr=%0d want data=%0d addr=%0d",
                                         m, i, got_data[i], got_addr[i], want[m], i);
                end
            end
        end
    endtask

    task automatic test_negative();
        int want [0:1];
        want = '{0, 8'hCE};
        for (int i = 0; i < 9; i++) kern[i] = (i == 4) ? -1 : 0;
        for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = 50;
        load_kernel();
        for (int m = 0; m < 2; m++) begin
            run_frame(0, 1 - m, 0, 95, 90, 0, 0, -1);
            checks++; if (got_data.size() != 676) begin failures++; $display("FAIL neg%0d_count got=%0d want=676", m, got_data.size()); end
            for (int i = 0; i < got_data.size(); i++) begin
                checks++;
                if (got_data[i] != want[m]) begin
                    failures++; $display("FAIL neg%0d_out[%0d] got=%0d want=%0d", m, i, got_data[i], want[m]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 9; i++) kern[i] = $urandom_range(0, 255) - 128;
        random_image();
        load_kernel();
        build_expected(1, 0, 3);
        run_frame(1, 0, 3, 100, 35, 1, 0, -1);
        checks++; if (timed_out) begin failures++; $display("FAIL backpressure_timeout got=timeout want=done"); end
        checks++; if (got_data.size() != exp_q.size()) begin
            failures++; $display("FAIL backpressure_count got=%0d want=%0d", got_data.size(), exp_q.size());
        end
        for (int i = 0; i < got_data.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_data[i] != exp_q[i] || got_addr[i] != i) begin
                failures++; $display("FAIL backpressure_out[%0d] got data=%0d addr=%0d want data=%0d addr=%0d",
                                     i, got_data[i], got_addr[i], exp_q[i], i);
            end
        end
        checks++; if (prot_err != 0) begin failures++; $display("FAIL backpressure_hold got=%0d violations want=0", prot_err); end
        checks++; if (lat_err != 0) begin failures++; $display("FAIL backpressure_latency got=%0d errors want=0", lat_err); end
    endtask

    task automatic test_random();
        int sv, rv, shv, kw;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 9; i++) kern[i] = $urandom_range(0, 255) - 128;
            random_image();
            load_kernel();
            kw = -1;
            if (f == 0) begin
                kw = $urandom_range(0, 8);
                kern[kw] = $urandom_range(0, 255) - 128;
            end
            sv = $urandom_range(0, 3); rv = $urandom_range(0, 1); shv = $urandom_range(0, 10);
            build_expected(sv, rv, shv);
            run_frame(sv, rv, shv, $urandom_range(50, 100), $urandom_range(40, 100), 0, (f == 1) ? 4 : 0, kw);
            checks++; if (timed_out) begin failures++; $display("FAIL rand%0d_timeout got=timeout want=done", f); end
            checks++; if (got_data.size() != exp_q.size()) begin
                failures++; $display("FAIL rand%0d_count got=%0d want=%0d", f, got_data.size(), exp_q.size());
            end
            for (int i = 0; i < got_data.size() && i < exp_q.size(); i++) begin
                checks++;
                if (got_data[i] != exp_q[i] || got_addr[i] != i) begin
                    failures++; $display("FAIL rand%0d_out[%0d] got data=%0d addr=%0d want data=%0d addr=%0d",
                                         f, i, got_data[i], got_addr[i], exp_q[i], i);
                end
            end
            checks++; if (idle_err != 0) begin failures++; $display("FAIL rand%0d_idle_run got=%0d errors want=0", f, idle_err); end
            checks++; if (done_cnt != 1 || prot_err != 0 || lat_err != 0) begin
                failures++; $display("FAIL rand%0d_protocol got done=%0d err=%0d/%0d want done=1 err=0/0", f, done_cnt, prot_err, lat_err);
            end
        end
    endtask

    task automatic test_midframe_reset();
        for (int i = 0; i < 9; i++) kern[i] = $urandom_range(1, 100);
        load_kernel();
        start = 1'b1; stride = 2'd0; relu_en = 1'b1; shift_amt = '0;
        @(posedge clk); #1;
        start = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            pix_valid = 1'b1; pix_data = BD'($urandom);
            if (i >= 97) out_ready = 1'b0;
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin
            failures++; $display("FAIL midreset_pre got busy=%b out_valid=%b want 1/1", busy, out_valid);
        end
        pix_valid = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_addr !== '0) begin
            failures++; $display("FAIL midreset_out got valid=%b data=%0d addr=%0d want 0/0/0", out_valid, out_data, out_addr);
        end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || pix_ready !== 1'b0) begin
            failures++; $display("FAIL midreset_ctrl got busy=%b done=%b pix_ready=%b want 0/0/0", busy, done, pix_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) kern[i] = 0;
        random_image();
        build_expected(0, 0, 0);
        run_frame(0, 0, 0, 90, 90, 0, 0, -1);
        checks++; if (got_data.size() != 676) begin failures++; $display("FAIL midreset_count got=%0d want=676", got_data.size()); end
        for (int i = 0; i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] != exp_q[i] || got_addr[i] != i) begin
                failures++; $display("FAIL midreset_kernel_cleared[%0d] got data=%0d addr=%0d want data=%0d addr=%0d",
                                     i, got_data[i], got_addr[i], exp_q[i], i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_stride2();
        test_saturation();
        test_negative();
        test_backpressure();
        test_random();
        test_midframe_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
